// File: rtl/silife_grid_sequencer.sv
// Command sequencer for the Silife grid core: turns LOAD / RUN / DUMP commands
// into grid en / wr_en / row_select / grid_in pin sequences with byte handshakes.
module silife_grid_sequencer #(
    parameter int unsigned ROWS     = 32,
    parameter int unsigned ROW_W    = 8,
    parameter int unsigned READ_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [7:0]       cmd_count,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ROW_W-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ROW_W-1:0] out_data,
    output logic             grid_en,
    output logic             grid_wr_en,
    output logic [4:0]       grid_row_select,
    output logic [ROW_W-1:0] grid_in,
    input  logic [ROW_W-1:0] grid_out,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DUMP_ADDR,
        S_DUMP_WAIT,
        S_DUMP_OUT,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        OP_NOP  = 2'd0,
        OP_LOAD = 2'd1,
        OP_RUN  = 2'd2,
        OP_DUMP = 2'd3
    } op_t;

    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
    localparam logic [1:0] LAT      = 2'(READ_LAT);

    state_t     state;
    state_t     state_next;
    logic [4:0] row;
    logic [4:0] row_sel_q;
    logic [7:0] gen;
    logic [1:0] wait_cnt;
    logic       cmd_fire;
    logic       in_fire;
    logic       out_fire;

    assign cmd_fire = cmd_valid && (state == S_IDLE);
    assign in_ready = (state == S_LOAD);
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready && (state == S_DUMP_OUT);

    // Writes are zero-latency: select/data follow the accepted byte in the same cycle.
    assign grid_en         = (state == S_RUN);
    assign grid_wr_en      = in_fire;
    assign grid_in         = in_fire ? in_data : '0;
    assign grid_row_select = in_fire ? row : row_sel_q;

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE: begin
                if (cmd_fire) begin
                    unique case (op_t'(cmd_op))
                        OP_NOP:  state_next = S_DONE;
                        OP_LOAD: state_next = S_LOAD;
                        OP_RUN:  state_next = (cmd_count == 8'd0) ? S_DONE : S_RUN;
                        OP_DUMP: state_next = S_DUMP_ADDR;
                    endcase
                end
            end
            S_LOAD: begin
                if (in_fire && row == LAST_ROW) state_next = S_DONE;
            end
            S_RUN: begin
                if (gen == 8'd1) state_next = S_DONE;
            end
            S_DUMP_ADDR: state_next = (LAT == 2'd0) ? S_DUMP_OUT : S_DUMP_WAIT;
            S_DUMP_WAIT: begin
                if (wait_cnt <= 2'd1) state_next = S_DUMP_OUT;
            end
            S_DUMP_OUT: begin
                if (out_fire) state_next = (row == LAST_ROW) ? S_DONE : S_DUMP_ADDR;
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            row       <= '0;
            row_sel_q <= '0;
            gen       <= '0;
            wait_cnt  <= '0;
            out_data  <= '0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_next;
            cmd_ready <= (state_next == S_IDLE);
            busy      <= (state_next != S_IDLE);
            out_valid <= (state_next == S_DUMP_OUT);
            done      <= (state_next == S_DONE);

            // Capture once on entry so the byte stays stable under back-pressure.
            if (state_next == S_DUMP_OUT && state != S_DUMP_OUT) out_data <= grid_out;

            unique case (state)
                S_IDLE: begin
                    if (cmd_fire) begin
                        row <= '0;
                        gen <= cmd_count;
                        if (op_t'(cmd_op) == OP_DUMP) row_sel_q <= '0;
                    end
                end
                S_LOAD: begin
                    if (in_fire) begin
                        row_sel_q <= row;
                        if (row != LAST_ROW) row <= row + 5'd1;
                    end
                end
                S_RUN:       gen      <= gen - 8'd1;
                S_DUMP_ADDR: wait_cnt <= LAT;
                S_DUMP_WAIT: wait_cnt <= wait_cnt - 2'd1;
                S_DUMP_OUT: begin
                    if (out_fire && row != LAST_ROW) begin
                        row       <= row + 5'd1;
                        row_sel_q <= row + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_silife_grid_sequencer.sv
// Directed bench for silife_grid_sequencer with a behavioural Life grid model
// (dead boundary, one-cycle registered read) attached to the grid pins.
module tb_silife_grid_sequencer;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_count;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       grid_en;
    logic       grid_wr_en;
    logic [4:0] grid_row_select;
    logic [7:0] grid_in;
    logic [7:0] grid_out;
    logic       busy;
    logic       done;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    int unsigned en_cycles   = 0;
    int unsigned wr_cycles   = 0;
    int unsigned done_cnt    = 0;

    logic [7:0]       img     [32];
    logic [7:0]       exp_img [32];
    logic [31:0][7:0] mem;
    logic             grid_mode;

    silife_grid_sequencer #(
        .ROWS    (32),
        .ROW_W   (8),
        .READ_LAT(1)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_op         (cmd_op),
        .cmd_count      (cmd_count),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .grid_en        (grid_en),
        .grid_wr_en     (grid_wr_en),
        .grid_row_select(grid_row_select),
        .grid_in        (grid_in),
        .grid_out       (grid_out),
        .busy           (busy),
        .done           (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0][7:0] life_step(input logic [31:0][7:0] g);
        logic [31:0][7:0] n;
        int cnt;
        for (int r = 0; r < 32; r++) begin
            for (int c = 0; c < 8; c++) begin
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < 32 &&
                            c + dc >= 0 && c + dc < 8) begin
                            if (g[r+dr][c+dc]) cnt++;
                        end
                    end
                end
                n[r][c] = (cnt == 3) || (g[r][c] && cnt == 2);
            end
        end
        return n;
    endfunction

    // Grid model: write wins over step; grid_out is one cycle behind row_select.
    always @(posedge clk) begin
        if (grid_wr_en) mem[grid_row_select] <= grid_in;
        else if (grid_en) mem <= life_step(mem);
        grid_out <= grid_mode ? ({3'b000, grid_row_select} ^ 8'hA5) : mem[grid_row_select];
    end

    always @(negedge clk) begin
        check("en_wr_excl", 32'(grid_en & grid_wr_en), 0);
        if (!grid_wr_en) check("grid_in_idle", 32'(grid_in), 0);
        if (cmd_valid && busy) check("cmd_ready_busy", 32'(cmd_ready), 0);
        if (grid_en) en_cycles++;
        if (grid_wr_en) wr_cycles++;
        if (done) done_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [7:0] cnt);
        int unsigned t = 0;
        while (!cmd_ready && t < 100) begin
            step();
            t++;
        end
        if (t >= 100) check("cmd_ready_timeout", 0, 1);
        en_cycles = 0;
        wr_cycles = 0;
        done_cnt  = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_count = cnt;
        step();
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_count = 8'd0;
    endtask

    task automatic wait_done(input string tag, input int unsigned exp_n);
        int unsigned n = 0;
        bit seen = 1'b0;
        while (!seen && n < 2000) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            else begin
                step();
                n++;
            end
        end
        check({tag, "_done_seen"}, 32'(seen), 1);
        if (seen) check({tag, "_done_lat"}, n, exp_n);
        step();
        @(negedge clk);
        check({tag, "_idle_ready"}, 32'(cmd_ready), 1);
        check({tag, "_done_once"}, done_cnt, 1);
        step();
    endtask

    task automatic load_rows(input bit gaps, input int unsigned nrows);
        int unsigned k = 0;
        int unsigned cyc = 0;
        while (k < nrows && cyc < 500) begin
            in_valid = !(gaps && (cyc % 3 == 2));
            in_data  = img[k];
            @(negedge clk);
            check("load_in_ready", 32'(in_ready), 1);
            if (in_valid) begin
                check("load_wr_en", 32'(grid_wr_en), 1);
                check("load_row", 32'(grid_row_select), k);
                check("load_data", 32'(grid_in), 32'(img[k]));
            end else begin
                check("load_gap_wr", 32'(grid_wr_en), 0);
            end
            step();
            if (in_valid) k++;
            cyc++;
        end
        in_valid = 1'b0;
        if (k != nrows) check("load_timeout", k, nrows);
    endtask

    task automatic dump_rows(input bit toggle);
        int unsigned got = 0;
        int unsigned cyc = 0;
        bit stalled = 1'b0;
        logic [7:0] held = '0;
        while (got < 32 && cyc < 1000) begin
            out_ready = toggle ? (cyc % 2 == 0) : 1'b1;
            @(negedge clk);
            if (out_valid) begin
                if (stalled) check("dump_hold", 32'(out_data), 32'(held));
                if (out_ready) begin
                    check("dump_byte", 32'(out_data), 32'(exp_img[got]));
                    got++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held    = out_data;
                end
            end
            step();
            cyc++;
        end
        out_ready = 1'b0;
        if (got != 32) check("dump_timeout", got, 32);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_count = 8'd0;
        in_valid  = 1'b0;
        in_data   = 8'd0;
        out_ready = 1'b0;
        grid_mode = 1'b0;

        @(negedge clk);
        @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_grid_en", 32'(grid_en), 0);
        check("rst_row_sel", 32'(grid_row_select), 0);
        check("rst_out_data", 32'(out_data), 0);
        step();
        rst = 1'b0;
        step();

        // NOP completes through DONE immediately
        send_cmd(2'd0, 8'd0);
        wait_done("nop", 0);

        // LOAD 0x00..0x1F with a gap every third cycle
        for (int i = 0; i < 32; i++) img[i] = 8'(i);
        send_cmd(2'd1, 8'd0);
        @(negedge clk);
        check("load_busy", 32'(busy), 1);
        step();
        load_rows(1'b1, 32);
        wait_done("load", 0);
        check("load_wr_pulses", wr_cycles, 32);
        check("load_mem5", 32'(mem[5]), 32'h05);
        check("load_mem31", 32'(mem[31]), 32'h1F);

        // RUN 5 then RUN 0
        send_cmd(2'd2, 8'd5);
        wait_done("run5", 5);
        check("run5_en_cycles", en_cycles, 5);
        send_cmd(2'd2, 8'd0);
        wait_done("run0", 0);
        check("run0_en_cycles", en_cycles, 0);

        // DUMP against row_select ^ 0xA5 with toggling out_ready
        grid_mode = 1'b1;
        for (int i = 0; i < 32; i++) exp_img[i] = 8'(i) ^ 8'hA5;
        send_cmd(2'd3, 8'd0);
        dump_rows(1'b1);
        wait_done("dump_xor", 0);
        grid_mode = 1'b0;

        // Glider round trip, with a DUMP offered while RUN is busy
        for (int i = 0; i < 32; i++) img[i] = 8'h00;
        img[2] = 8'h08;
        img[3] = 8'h10;
        img[4] = 8'h1C;
        send_cmd(2'd1, 8'd0);
        load_rows(1'b0, 32);
        wait_done("glider_load", 0);
        send_cmd(2'd2, 8'd4);
        cmd_valid = 1'b1;
        cmd_op    = 2'd3;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("busy_cmd_ready", 32'(cmd_ready), 0);
            step();
        end
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        wait_done("glider_run", 2);
        check("glider_en_cycles", en_cycles, 4);
        check("glider_no_dump", 32'(out_valid), 0);
        for (int i = 0; i < 32; i++) exp_img[i] = 8'h00;
        exp_img[3] = 8'h10;
        exp_img[4] = 8'h20;
        exp_img[5] = 8'h38;
        send_cmd(2'd3, 8'd0);
        dump_rows(1'b0);
        wait_done("glider_dump", 0);

        // Reset after row 10 of a LOAD, then a fresh LOAD from row 0
        for (int i = 0; i < 32; i++) img[i] = 8'h40 + 8'(i);
        send_cmd(2'd1, 8'd0);
        load_rows(1'b0, 11);
        in_valid = 1'b1;
        in_data  = 8'h77;
        #1;
        check("abort_pre_wr", 32'(grid_wr_en), 1);
        check("abort_pre_row", 32'(grid_row_select), 11);
        #1;
        rst = 1'b1;
        #1;
        check("abort_wr_en", 32'(grid_wr_en), 0);
        check("abort_in_ready", 32'(in_ready), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_cmd_ready", 32'(cmd_ready), 1);
        check("abort_row_sel", 32'(grid_row_select), 0);
        step();
        in_valid = 1'b0;
        step();
        rst = 1'b0;
        step();
        check("abort_no_done", done_cnt, 0);
        for (int i = 0; i < 32; i++) img[i] = 8'h80 + 8'(i);
        send_cmd(2'd1, 8'd0);
        load_rows(1'b0, 32);
        wait_done("reload", 0);
        check("reload_mem0", 32'(mem[0]), 32'h80);
        check("reload_mem11", 32'(mem[11]), 32'h8B);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
